// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data RAM.
// Each access takes three cycles: latch and check in IDLE, RAM strobe in ACCESS, ack in DONE.
module mem_arbiter #(
  parameter int unsigned MEM_SIZE = 128
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [2:0]  m0_funct3,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [2:0]  m1_funct3,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,

  output logic [31:0] ram_address,
  output logic [31:0] ram_writeData,
  output logic [2:0]  ram_funct3,
  output logic        ram_memRead,
  output logic        ram_memWrite,
  input  logic [31:0] ram_readData
);

  localparam logic [31:0] LastAddr = 32'(MEM_SIZE - 4);
  localparam logic [2:0]  F3Word   = 3'b010;
  localparam logic [2:0]  F3Byte   = 3'b000;
  localparam logic [2:0]  F3ByteU  = 3'b100;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state_q, state_d;

  logic        last_q, last_d;   // port granted most recently
  logic        win_q, win_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic        valid_q, valid_d;

  logic        ack0_q, ack0_d, ack1_q, ack1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic        any_req;
  logic        sel;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_f3;
  logic        sel_f3_ok;
  logic        sel_valid;
  logic [31:0] load_data;

  // Winner selection and validity of the candidate request.
  always_comb begin
    any_req = m0_req | m1_req;
    sel     = (m0_req && m1_req) ? ~last_q : m1_req;
    if (sel) begin
      sel_we    = m1_we;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
      sel_f3    = m1_funct3;
    end else begin
      sel_we    = m0_we;
      sel_addr  = m0_addr;
      sel_wdata = m0_wdata;
      sel_f3    = m0_funct3;
    end
    case (sel_f3)
      F3Word, F3Byte: sel_f3_ok = 1'b1;
      F3ByteU:        sel_f3_ok = ~sel_we;
      default:        sel_f3_ok = 1'b0;
    endcase
    sel_valid = (sel_addr[1:0] == 2'b00) && (sel_addr <= LastAddr) && sel_f3_ok;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (any_req) state_d = StAccess;
      StAccess: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs: the RAM port is only driven during ACCESS of a valid request.
  always_comb begin
    ram_address   = '0;
    ram_writeData = '0;
    ram_funct3    = '0;
    ram_memRead   = 1'b0;
    ram_memWrite  = 1'b0;
    if (state_q == StAccess && valid_q) begin
      ram_address   = addr_q;
      ram_writeData = wdata_q;
      ram_funct3    = f3_q;
      ram_memWrite  = we_q;
      ram_memRead   = ~we_q;
    end
  end

  // Request latch, grant pointer and registered per-port responses.
  always_comb begin
    win_d     = win_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    f3_d      = f3_q;
    valid_d   = valid_q;
    last_d    = last_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    rdata0_d  = '0;
    rdata1_d  = '0;
    load_data = (valid_q && !we_q) ? ram_readData : '0;

    if (state_q == StIdle && any_req) begin
      win_d   = sel;
      we_d    = sel_we;
      addr_d  = sel_addr;
      wdata_d = sel_wdata;
      f3_d    = sel_f3;
      valid_d = sel_valid;
    end

    // Responses are loaded on the ACCESS->DONE edge so they are visible during DONE.
    if (state_q == StAccess) begin
      last_d = win_q;
      if (win_q) begin
        ack1_d   = 1'b1;
        err1_d   = ~valid_q;
        rdata1_d = load_data;
      end else begin
        ack0_d   = 1'b1;
        err0_d   = ~valid_q;
        rdata0_d = load_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      f3_q     <= '0;
      valid_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      last_q   <= last_d;
      win_q    <= win_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      f3_q     <= f3_d;
      valid_q  <= valid_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign m0_ack   = ack0_q;
  assign m0_err   = err0_q;
  assign m0_rdata = rdata0_q;
  assign m1_ack   = ack1_q;
  assign m1_err   = err1_q;
  assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_mem_arbiter;

  localparam int unsigned MemSize = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [2:0]  m0_funct3, m1_funct3;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] ram_address, ram_writeData, ram_readData;
  logic [2:0]  ram_funct3;
  logic        ram_memRead, ram_memWrite;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_SIZE(MemSize)) dut (
    .clk          (clk),
    .rst          (rst),
    .m0_req       (m0_req),
    .m0_we        (m0_we),
    .m0_addr      (m0_addr),
    .m0_wdata     (m0_wdata),
    .m0_funct3    (m0_funct3),
    .m0_ack       (m0_ack),
    .m0_err       (m0_err),
    .m0_rdata     (m0_rdata),
    .m1_req       (m1_req),
    .m1_we        (m1_we),
    .m1_addr      (m1_addr),
    .m1_wdata     (m1_wdata),
    .m1_funct3    (m1_funct3),
    .m1_ack       (m1_ack),
    .m1_err       (m1_err),
    .m1_rdata     (m1_rdata),
    .ram_address  (ram_address),
    .ram_writeData(ram_writeData),
    .ram_funct3   (ram_funct3),
    .ram_memRead  (ram_memRead),
    .ram_memWrite (ram_memWrite),
    .ram_readData (ram_readData)
  );

  int total = 0;
  int bad   = 0;
  int model_last = 1;  // port granted most recently, per the model

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_funct3 = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_funct3 = 0;
  endtask

  task automatic drive(input int p, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f3);
    if (p == 0) begin
      m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = wd; m0_funct3 = f3;
    end else begin
      m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = wd; m1_funct3 = f3;
    end
  endtask

  function automatic bit model_valid(logic we, logic [31:0] a, logic [2:0] f3);
    bit f3_ok;
    f3_ok = (f3 == 3'd2) || (f3 == 3'd0) || (f3 == 3'd4 && !we);
    return (a % 4 == 0) && (a <= MemSize - 4) && f3_ok;
  endfunction

  function automatic int model_pick(bit r0, bit r1);
    if (r0 && r1) return (model_last == 1) ? 0 : 1;
    return r1 ? 1 : 0;
  endfunction

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
    model_last = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    ram_readData = 32'hFFFF_FFFF;
    rst = 1;
    drive(0, 1'b0, 32'h0, 32'h0, 3'b010);
    tick();
    tick();
    total++;
    if ({m0_ack, m1_ack, m0_err, m1_err, ram_memRead, ram_memWrite} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 000000",
               {m0_ack, m1_ack, m0_err, m1_err, ram_memRead, ram_memWrite});
    end
    total++;
    if ({m0_rdata, m1_rdata, ram_address, ram_writeData, ram_funct3} !== '0) begin
      bad++;
      $display("FAIL reset_data: rdata0=%h rdata1=%h addr=%h wd=%h f3=%b want all 0",
               m0_rdata, m1_rdata, ram_address, ram_writeData, ram_funct3);
    end
    idle_inputs();
    rst = 0;
    model_last = 1;
    tick();
  endtask

  task automatic test_store();
    drive(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010);
    tick();
    total++;
    if ({ram_memWrite, ram_memRead} !== 2'b10 || ram_address !== 32'h10 ||
        ram_writeData !== 32'hDEAD_BEEF || ram_funct3 !== 3'b010) begin
      bad++;
      $display("FAIL store_ram: wr=%b rd=%b addr=%h wd=%h f3=%b want 1 0 10 deadbeef 010",
               ram_memWrite, ram_memRead, ram_address, ram_writeData, ram_funct3);
    end
    total++;
    if (m0_ack !== 1'b0) begin
      bad++;
      $display("FAIL store_early_ack: got %b want 0", m0_ack);
    end
    tick();
    total++;
    if ({m0_ack, m0_err, m1_ack} !== 3'b100 || m0_rdata !== 32'h0) begin
      bad++;
      $display("FAIL store_ack: ack/err/ack1=%b rdata=%h want 100 0",
               {m0_ack, m0_err, m1_ack}, m0_rdata);
    end
    model_last = 0;
    idle_inputs();
    tick();
    total++;
    if ({m0_ack, ram_memWrite, ram_memRead} !== 3'b000) begin
      bad++;
      $display("FAIL store_after: ack/wr/rd=%b want 000", {m0_ack, ram_memWrite, ram_memRead});
    end
  endtask

  task automatic test_load();
    logic [31:0] vals[2];
    vals[0] = 32'h0000_00F0;
    vals[1] = 32'hFFFF_FF80;
    for (int i = 0; i < 2; i++) begin
      drive(1, 1'b0, 32'h10, 32'h0, 3'b000);
      ram_readData = vals[i];
      tick();
      total++;
      if ({ram_memRead, ram_memWrite} !== 2'b10 || ram_funct3 !== 3'b000) begin
        bad++;
        $display("FAIL load_strobe[%0d]: rd=%b wr=%b f3=%b want 1 0 000",
                 i, ram_memRead, ram_memWrite, ram_funct3);
      end
      tick();
      total++;
      if ({m1_ack, m1_err, m0_ack} !== 3'b100 || m1_rdata !== vals[i] || m0_rdata !== 0) begin
        bad++;
        $display("FAIL load_ack[%0d]: ack/err/ack0=%b rdata=%h want 100 %h",
                 i, {m1_ack, m1_err, m0_ack}, m1_rdata, vals[i]);
      end
      model_last = 1;
      idle_inputs();
      tick();
      total++;
      if (m1_rdata !== 32'h0) begin
        bad++;
        $display("FAIL load_rdata_clear[%0d]: got %h want 0", i, m1_rdata);
      end
    end
  endtask

  task automatic test_round_robin();
    int acks = 0;
    int prev = 0;
    int port;
    int exp;
    idle_inputs();
    do_reset();
    drive(0, 1'b0, 32'h4, 32'h0, 3'b010);
    drive(1, 1'b0, 32'h8, 32'h0, 3'b010);
    ram_readData = 32'h1357_9BDF;
    for (int cyc = 1; cyc <= 20 && acks < 4; cyc++) begin
      tick();
      if (m0_ack || m1_ack) begin
        port = m1_ack ? 1 : 0;
        exp  = model_pick(1'b1, 1'b1);
        model_last = exp;
        total++;
        if ((m0_ack && m1_ack) || port != exp) begin
          bad++;
          $display("FAIL rr_winner[%0d]: ack0=%b ack1=%b want port %0d", acks, m0_ack, m1_ack, exp);
        end
        if (acks > 0) begin
          total++;
          if (cyc - prev != 3) begin
            bad++;
            $display("FAIL rr_spacing[%0d]: got %0d cycles want 3", acks, cyc - prev);
          end
        end
        prev = cyc;
        acks++;
      end
    end
    total++;
    if (acks != 4) begin
      bad++;
      $display("FAIL rr_timeout: got %0d acks want 4", acks);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_invalid();
    logic        we[4];
    logic [31:0] a[4];
    logic [2:0]  f3[4];
    logic        exp_err[4];
    we[0] = 0; a[0] = 32'h12; f3[0] = 3'b010; exp_err[0] = 1;
    we[1] = 0; a[1] = 32'h7C; f3[1] = 3'b010; exp_err[1] = 0;
    we[2] = 0; a[2] = 32'h80; f3[2] = 3'b010; exp_err[2] = 1;
    we[3] = 1; a[3] = 32'h10; f3[3] = 3'b100; exp_err[3] = 1;
    for (int i = 0; i < 4; i++) begin
      drive(0, we[i], a[i], 32'hCAFE_0000 + 32'(i), f3[i]);
      ram_readData = 32'hA000_0000 + 32'(i);
      tick();
      total++;
      if ({ram_memRead, ram_memWrite} !== (exp_err[i] ? 2'b00 : 2'b10)) begin
        bad++;
        $display("FAIL inv_strobe[%0d]: rd=%b wr=%b want err=%b strobe", i,
                 ram_memRead, ram_memWrite, exp_err[i]);
      end
      tick();
      total++;
      if (m0_ack !== 1'b1 || m0_err !== exp_err[i] ||
          m0_rdata !== (exp_err[i] ? 32'h0 : 32'hA000_0000 + 32'(i))) begin
        bad++;
        $display("FAIL inv_ack[%0d]: ack=%b err=%b rdata=%h want 1 %b", i,
                 m0_ack, m0_err, m0_rdata, exp_err[i]);
      end
      model_last = 0;
      idle_inputs();
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 1'b1, 32'h20, 32'h1111_2222, 3'b010);
    tick();
    rst = 1;
    tick();
    total++;
    if ({m0_ack, m1_ack, m0_err, m1_err, ram_memRead, ram_memWrite} !== 6'b0 ||
        {m0_rdata, m1_rdata, ram_address, ram_writeData, ram_funct3} !== '0) begin
      bad++;
      $display("FAIL rst_mid: flags=%b addr=%h want all 0",
               {m0_ack, m1_ack, m0_err, m1_err, ram_memRead, ram_memWrite}, ram_address);
    end
    rst = 0;
    model_last = 1;
    tick();
    total++;
    if (ram_memWrite !== 1'b1 || ram_address !== 32'h20) begin
      bad++;
      $display("FAIL rst_mid_retry_strobe: wr=%b addr=%h want 1 20", ram_memWrite, ram_address);
    end
    tick();
    total++;
    if (m0_ack !== 1'b1 || m0_err !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_retry_ack: ack=%b err=%b want 1 0", m0_ack, m0_err);
    end
    model_last = 0;
    idle_inputs();
    tick();
  endtask

  task automatic test_drop_req();
    drive(0, 1'b0, 32'h40, 32'h0, 3'b010);
    tick();
    m0_req = 0;
    ram_readData = 32'h0000_A5A5;
    total++;
    if (ram_memRead !== 1'b1) begin
      bad++;
      $display("FAIL drop_strobe: rd=%b want 1", ram_memRead);
    end
    tick();
    total++;
    if (m0_ack !== 1'b1 || m0_rdata !== 32'h0000_A5A5) begin
      bad++;
      $display("FAIL drop_ack: ack=%b rdata=%h want 1 0000a5a5", m0_ack, m0_rdata);
    end
    model_last = 0;
    idle_inputs();
    tick();
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 4))
      0:       return 32'($urandom_range(0, MemSize / 4 - 1) * 4);
      1:       return 32'($urandom_range(0, MemSize / 4 - 1) * 4 + $urandom_range(1, 3));
      2:       return 32'(MemSize - 4);
      3:       return 32'(MemSize);
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [2:0] rand_f3();
    case ($urandom_range(0, 3))
      0:       return 3'b000;
      1:       return 3'b010;
      2:       return 3'b100;
      default: return 3'($urandom_range(0, 7));
    endcase
  endfunction

  task automatic test_random();
    bit          r[2];
    logic        we[2];
    logic [31:0] a[2];
    logic [31:0] wd[2];
    logic [2:0]  f3[2];
    logic [31:0] rd;
    int          w;
    bit          v;
    for (int it = 0; it < 60; it++) begin
      for (int p = 0; p < 2; p++) begin
        r[p]  = ($urandom_range(0, 3) != 0);
        we[p] = 1'($urandom_range(0, 1));
        a[p]  = rand_addr();
        wd[p] = $urandom;
        f3[p] = rand_f3();
      end
      m0_req = r[0]; m0_we = we[0]; m0_addr = a[0]; m0_wdata = wd[0]; m0_funct3 = f3[0];
      m1_req = r[1]; m1_we = we[1]; m1_addr = a[1]; m1_wdata = wd[1]; m1_funct3 = f3[1];
      tick();
      if (!r[0] && !r[1]) begin
        total++;
        if ({ram_memRead, ram_memWrite, m0_ack, m1_ack} !== 4'b0) begin
          bad++;
          $display("FAIL rnd_idle[%0d]: rd/wr/ack0/ack1=%b want 0000", it,
                   {ram_memRead, ram_memWrite, m0_ack, m1_ack});
        end
        continue;
      end
      w = model_pick(r[0], r[1]);
      v = model_valid(we[w], a[w], f3[w]);
      model_last = w;
      // Scramble both ports after latching; the access in flight must not notice.
      rd = $urandom;
      ram_readData = rd;
      m0_req = 1'($urandom_range(0, 1)); m0_addr = $urandom; m0_we = ~m0_we;
      m1_req = 1'($urandom_range(0, 1)); m1_addr = $urandom; m1_we = ~m1_we;
      m0_wdata = $urandom; m1_wdata = $urandom;
      #1;
      total++;
      if (ram_memWrite !== (v && we[w]) || ram_memRead !== (v && !we[w]) ||
          ram_address !== (v ? a[w] : 32'h0) || ram_writeData !== (v ? wd[w] : 32'h0) ||
          ram_funct3 !== (v ? f3[w] : 3'b0)) begin
        bad++;
        $display("FAIL rnd_ram[%0d]: wr=%b rd=%b addr=%h wd=%h f3=%b want port %0d valid=%b addr=%h",
                 it, ram_memWrite, ram_memRead, ram_address, ram_writeData, ram_funct3,
                 w, v, a[w]);
      end
      tick();
      total++;
      if ((w == 0 && ({m0_ack, m0_err, m1_ack, m1_err} !== {1'b1, !v, 2'b00} ||
                      m0_rdata !== ((v && !we[0]) ? rd : 32'h0) || m1_rdata !== 32'h0)) ||
          (w == 1 && ({m1_ack, m1_err, m0_ack, m0_err} !== {1'b1, !v, 2'b00} ||
                      m1_rdata !== ((v && !we[1]) ? rd : 32'h0) || m0_rdata !== 32'h0))) begin
        bad++;
        $display("FAIL rnd_ack[%0d]: ack0=%b err0=%b rd0=%h ack1=%b err1=%b rd1=%h want port %0d err=%b",
                 it, m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata, w, !v);
      end
      idle_inputs();
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_round_robin();
    test_invalid();
    test_reset_mid();
    test_drop_req();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
